// File: rtl/fila_param.sv
`default_nettype none
// ============================================================================
// Module   : fila_param
// Purpose  : Parametrised circular FIFO with status flags, sticky overflow and
//            underflow flags, a synchronous flush, and defined behaviour when
//            enqueue and dequeue arrive on the same edge. Commands are either
//            edge-triggered (0->1 transition) or level-triggered.
// Ports    : clock_10KHz     - system clock, rising edge
//            reset           - asynchronous, active-high
//            data_in         - word to enqueue
//            enqueue_in      - enqueue command
//            dequeue_in      - dequeue command
//            clear_in        - synchronous flush (level)
//            data_out        - last dequeued word (registered)
//            data_valid_out  - one-cycle pulse after data_out is updated
//            len_out         - occupancy, 0..DEPTH
//            empty_out / full_out / almost_full_out - occupancy flags
//            overflow_out / underflow_out           - sticky rejection flags
// Revision : 1.0 - initial release
// ============================================================================
module fila_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int AFULL_LVL = 6,
  parameter int EDGE_MODE = 1
) (
  input  logic                       clock_10KHz,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       enqueue_in,
  input  logic                       dequeue_in,
  input  logic                       clear_in,
  output logic [DATA_W-1:0]          data_out,
  output logic                       data_valid_out,
  output logic [$clog2(DEPTH+1)-1:0] len_out,
  output logic                       empty_out,
  output logic                       full_out,
  output logic                       almost_full_out,
  output logic                       overflow_out,
  output logic                       underflow_out
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH+1);

  localparam logic [LW-1:0] c_DEPTH = LW'(DEPTH);
  localparam logic [LW-1:0] c_AFULL = LW'(AFULL_LVL);

  // Storage is deliberately left without reset.
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [AW-1:0]     r_head;
  logic [AW-1:0]     r_tail;
  logic [LW-1:0]     r_len;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_ovf;
  logic              r_unf;
  logic              r_enq_q;
  logic              r_deq_q;

  logic              w_enq_ev;
  logic              w_deq_ev;
  logic              w_empty;
  logic              w_full;
  logic              w_enq_acc;
  logic              w_deq_acc;
  logic [LW-1:0]     w_len_nxt;

  // Flags come straight from the registered length.
  assign w_empty = (r_len == '0);
  assign w_full  = (r_len == c_DEPTH);

  // Command events: a rising transition in edge mode, the raw level otherwise.
  assign w_enq_ev = (EDGE_MODE != 0) ? (enqueue_in & ~r_enq_q) : enqueue_in;
  assign w_deq_ev = (EDGE_MODE != 0) ? (dequeue_in & ~r_deq_q) : dequeue_in;

  // Dequeue decides first so that a full FIFO can accept an enqueue into the
  // slot freed on the same edge. No bypass when empty.
  assign w_deq_acc = w_deq_ev & ~w_empty;
  assign w_enq_acc = w_enq_ev & (~w_full | w_deq_acc);

  assign w_len_nxt = r_len + {{(LW-1){1'b0}}, w_enq_acc}
                           - {{(LW-1){1'b0}}, w_deq_acc};

  // Edge-detect history follows the inputs regardless of clear_in.
  always_ff @(posedge clock_10KHz or posedge reset) begin
    if (reset) begin
      r_enq_q <= 1'b0;
      r_deq_q <= 1'b0;
    end else begin
      r_enq_q <= enqueue_in;
      r_deq_q <= dequeue_in;
    end
  end

  always_ff @(posedge clock_10KHz) begin
    if (!clear_in && w_enq_acc) begin
      r_mem[r_tail] <= data_in;
    end
  end

  always_ff @(posedge clock_10KHz or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_len   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (clear_in) begin
      // Flush: data_out keeps its last value.
      r_head  <= '0;
      r_tail  <= '0;
      r_len   <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_valid <= w_deq_acc;
      r_len   <= w_len_nxt;
      if (w_deq_acc) begin
        r_data <= r_mem[r_head];
        r_head <= r_head + 1'b1;
      end
      if (w_enq_acc) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_enq_ev && !w_enq_acc) begin
        r_ovf <= 1'b1;
      end
      if (w_deq_ev && !w_deq_acc) begin
        r_unf <= 1'b1;
      end
    end
  end

  assign data_out        = r_data;
  assign data_valid_out  = r_valid;
  assign len_out         = r_len;
  assign empty_out       = w_empty;
  assign full_out        = w_full;
  assign almost_full_out = (r_len >= c_AFULL);
  assign overflow_out    = r_ovf;
  assign underflow_out   = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_fila_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_fila_param
// Purpose  : Directed self-checking bench for fila_param (8x8, edge mode).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fila_param;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       enqueue_in;
  logic       dequeue_in;
  logic       clear_in;
  logic [7:0] data_out;
  logic       data_valid_out;
  logic [3:0] len_out;
  logic       empty_out;
  logic       full_out;
  logic       almost_full_out;
  logic       overflow_out;
  logic       underflow_out;

  int n_assert = 0;
  int n_fail   = 0;

  fila_param #(
    .DATA_W(8), .DEPTH(8), .AFULL_LVL(6), .EDGE_MODE(1)
  ) dut (
    .clock_10KHz    (clk),
    .reset          (reset),
    .data_in        (data_in),
    .enqueue_in     (enqueue_in),
    .dequeue_in     (dequeue_in),
    .clear_in       (clear_in),
    .data_out       (data_out),
    .data_valid_out (data_valid_out),
    .len_out        (len_out),
    .empty_out      (empty_out),
    .full_out       (full_out),
    .almost_full_out(almost_full_out),
    .overflow_out   (overflow_out),
    .underflow_out  (underflow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle enqueue pulse followed by a low cycle.
  task automatic enq(input logic [7:0] v);
    @(negedge clk);
    enqueue_in = 1'b1;
    data_in    = v;
    @(negedge clk);
    enqueue_in = 1'b0;
  endtask

  // One-cycle dequeue pulse; checks the word and the valid pulse the cycle after.
  task automatic deq(input string tag, input logic [7:0] exp);
    @(negedge clk);
    dequeue_in = 1'b1;
    @(negedge clk);
    dequeue_in = 1'b0;
    chk({tag, "_data"}, 32'(data_out), 32'(exp));
    chk({tag, "_valid"}, 32'(data_valid_out), 32'd1);
  endtask

  logic [7:0] held;

  initial begin
    reset      = 1'b1;
    data_in    = 8'h00;
    enqueue_in = 1'b0;
    dequeue_in = 1'b0;
    clear_in   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_len",   32'(len_out), 32'd0);
    chk("rst_empty", 32'(empty_out), 32'd1);
    chk("rst_full",  32'(full_out), 32'd0);
    chk("rst_afull", 32'(almost_full_out), 32'd0);
    chk("rst_ovf",   32'(overflow_out), 32'd0);
    chk("rst_unf",   32'(underflow_out), 32'd0);
    chk("rst_dv",    32'(data_valid_out), 32'd0);
    chk("rst_data",  32'(data_out), 32'd0);
    reset = 1'b0;

    // 1: three words in, three out
    enq(8'h11); enq(8'h22); enq(8'h33);
    chk("t1_len", 32'(len_out), 32'd3);
    chk("t1_empty", 32'(empty_out), 32'd0);
    deq("t1_d0", 8'h11);
    deq("t1_d1", 8'h22);
    deq("t1_d2", 8'h33);
    @(negedge clk);
    chk("t1_dv_drop", 32'(data_valid_out), 32'd0);
    chk("t1_len_end", 32'(len_out), 32'd0);

    // 2: fill, almost-full threshold, overflow, drain
    for (int i = 0; i < 8; i++) begin
      enq(8'(i));
      if (i == 4) chk("t2_afull_at5", 32'(almost_full_out), 32'd0);
      if (i == 5) chk("t2_afull_at6", 32'(almost_full_out), 32'd1);
    end
    chk("t2_full", 32'(full_out), 32'd1);
    chk("t2_len8", 32'(len_out), 32'd8);
    chk("t2_ovf_pre", 32'(overflow_out), 32'd0);
    enq(8'hAA);
    chk("t2_ovf", 32'(overflow_out), 32'd1);
    chk("t2_len_ovf", 32'(len_out), 32'd8);
    for (int i = 0; i < 8; i++) deq($sformatf("t2_d%0d", i), 8'(i));
    chk("t2_empty", 32'(empty_out), 32'd1);

    // 3: dequeue on empty
    @(negedge clk);
    dequeue_in = 1'b1;
    @(negedge clk);
    dequeue_in = 1'b0;
    chk("t3_unf", 32'(underflow_out), 32'd1);
    chk("t3_dv", 32'(data_valid_out), 32'd0);
    chk("t3_data", 32'(data_out), 32'h07);
    chk("t3_len", 32'(len_out), 32'd0);

    // flush sticky flags
    @(negedge clk);
    clear_in = 1'b1;
    @(negedge clk);
    clear_in = 1'b0;
    chk("clr_ovf", 32'(overflow_out), 32'd0);
    chk("clr_unf", 32'(underflow_out), 32'd0);
    chk("clr_data", 32'(data_out), 32'h07);

    // 4: simultaneous enqueue+dequeue when full, then when empty
    for (int i = 0; i < 8; i++) enq(8'h80 + 8'(i));
    @(negedge clk);
    enqueue_in = 1'b1; dequeue_in = 1'b1; data_in = 8'h55;
    @(negedge clk);
    enqueue_in = 1'b0; dequeue_in = 1'b0;
    chk("t4_data", 32'(data_out), 32'h80);
    chk("t4_dv", 32'(data_valid_out), 32'd1);
    chk("t4_len", 32'(len_out), 32'd8);
    chk("t4_ovf", 32'(overflow_out), 32'd0);
    for (int i = 1; i < 8; i++) deq($sformatf("t4_d%0d", i), 8'h80 + 8'(i));
    deq("t4_last", 8'h55);
    @(negedge clk);
    enqueue_in = 1'b1; dequeue_in = 1'b1; data_in = 8'h66;
    @(negedge clk);
    enqueue_in = 1'b0; dequeue_in = 1'b0;
    chk("t4e_len", 32'(len_out), 32'd1);
    chk("t4e_unf", 32'(underflow_out), 32'd1);
    chk("t4e_dv", 32'(data_valid_out), 32'd0);
    deq("t4e_d", 8'h66);

    // 5: wrap with alternating traffic, then a held enqueue
    for (int i = 0; i < 20; i++) begin
      enq(8'h30 + 8'(i));
      deq($sformatf("t5_w%0d", i), 8'h30 + 8'(i));
    end
    @(negedge clk);
    enqueue_in = 1'b1; data_in = 8'h99;
    repeat (5) @(negedge clk);
    enqueue_in = 1'b0;
    chk("t5_hold_len", 32'(len_out), 32'd1);
    deq("t5_hold_d", 8'h99);

    // 6: flush at len=5 with a sticky flag set
    @(negedge clk);
    clear_in = 1'b1;
    @(negedge clk);
    clear_in = 1'b0;
    @(negedge clk);
    dequeue_in = 1'b1;
    @(negedge clk);
    dequeue_in = 1'b0;
    for (int i = 0; i < 5; i++) enq(8'hA0 + 8'(i));
    chk("t6_len5", 32'(len_out), 32'd5);
    chk("t6_unf_set", 32'(underflow_out), 32'd1);
    held = data_out;
    @(negedge clk);
    clear_in = 1'b1;
    @(negedge clk);
    clear_in = 1'b0;
    chk("t6_len", 32'(len_out), 32'd0);
    chk("t6_empty", 32'(empty_out), 32'd1);
    chk("t6_unf", 32'(underflow_out), 32'd0);
    chk("t6_data_held", 32'(data_out), 32'h99);
    chk("t6_held_var", 32'(data_out), 32'(held));

    // async reset in the middle of a burst
    enq(8'hB0); enq(8'hB1); enq(8'hB2);
    @(negedge clk);
    dequeue_in = 1'b1;
    @(posedge clk);
    #2;
    chk("t6_pre_dv", 32'(data_valid_out), 32'd1);
    reset = 1'b1;
    #1;
    chk("ar_len",   32'(len_out), 32'd0);
    chk("ar_empty", 32'(empty_out), 32'd1);
    chk("ar_data",  32'(data_out), 32'd0);
    chk("ar_dv",    32'(data_valid_out), 32'd0);
    chk("ar_afull", 32'(almost_full_out), 32'd0);
    chk("ar_unf",   32'(underflow_out), 32'd0);
    dequeue_in = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("ar_after_len", 32'(len_out), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
